// File: rtl/iob_eth_frame_buf_pkg.sv
// ============================================================================
// Module      : iob_eth_frame_buf_pkg
// Description : Shared types and helpers for the Ethernet frame buffer.
//               Write FSM encodings (WR_IDLE/WR_FILL/WR_DROP), read FSM
//               encodings (RD_IDLE/RD_FETCH/RD_STREAM) and a saturating
//               increment for the optional drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iob_eth_frame_buf_pkg;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FILL = 2'd1,
        WR_DROP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_FETCH  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

    localparam int c_DROP_CNT_W = 16;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [c_DROP_CNT_W-1:0] sat_inc16(input logic [c_DROP_CNT_W-1:0] v);
        return (v == {c_DROP_CNT_W{1'b1}}) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iob_eth_frame_buf_ram.sv
// ============================================================================
// Module      : iob_eth_frame_buf_ram
// Description : Single-clock simple-dual-port RAM with registered read.
//               The read register only loads when i_re is high, so o_rdata
//               holds its value while the consumer stalls.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_re     - read enable (loads o_rdata)
//               i_raddr  - read address
//               o_rdata  - registered read data (one cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_eth_frame_buf_ram #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/iob_eth_frame_buf.sv
// ============================================================================
// Module      : iob_eth_frame_buf
// Description : Multi-slot Ethernet frame buffer. Whole frames from the MAC
//               byte stream are stored in 2**NSLOTS_W slots of 2**ADDR_W
//               beats; committed frames are replayed in order on a
//               valid/ready stream. Aborted, overflowing or full-time frames
//               are discarded and never reach the reader.
// Ports       : clk, rst (async, active-high)
//               wr_en/wr_data/wr_last/wr_abort  - MAC-side write stream
//               rd_valid/rd_ready/rd_data/rd_last/rd_len - read stream
//               frame_cnt/full/empty           - occupancy status
//               drop_cnt                        - dropped-frame counter
//                                                 (IOB_ETH_FRAME_BUF_DROP_CNT_EN)
// Config      : define IOB_ETH_FRAME_BUF_DROP_CNT_EN to add drop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_eth_frame_buf
    import iob_eth_frame_buf_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 11,
    parameter int NSLOTS_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_last,
    input  logic                wr_abort,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic [ADDR_W:0]     rd_len,
    output logic [NSLOTS_W:0]   frame_cnt,
    output logic                full,
    output logic                empty
`ifdef IOB_ETH_FRAME_BUF_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    localparam int                  c_NSLOTS     = 2**NSLOTS_W;
    localparam int                  c_RAM_ADDR_W = NSLOTS_W + ADDR_W;
    localparam logic [ADDR_W-1:0]   c_WPTR_MAX   = '1;
    localparam logic [ADDR_W-1:0]   c_WPTR_ONE   = 1;
    localparam logic [ADDR_W:0]     c_LEN_ONE    = 1;
    localparam logic [ADDR_W:0]     c_LEN_TWO    = 2;
    localparam logic [NSLOTS_W-1:0] c_SLOT_ONE   = 1;
    localparam logic [NSLOTS_W:0]   c_CNT_ONE    = 1;
    localparam logic [NSLOTS_W:0]   c_FULL_CNT   = c_CNT_ONE << NSLOTS_W;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    wr_state_t             r_wr_state, w_wr_state_nxt;
    logic [NSLOTS_W-1:0]   r_wslot;
    logic [ADDR_W-1:0]     r_wptr, w_wptr_nxt;
    logic                  w_ram_we;
    logic                  w_commit;
    logic                  w_drop_evt;
    logic [ADDR_W:0]       w_commit_len;
    logic [ADDR_W:0]       r_len [c_NSLOTS];

    logic [NSLOTS_W:0]     r_frame_cnt, w_frame_cnt_nxt;
    logic                  r_full, r_empty;

    // wptr is 0 in IDLE, so the same address/length expressions serve a
    // one-beat frame committed straight from IDLE.
    assign w_commit_len = {1'b0, r_wptr} + c_LEN_ONE;

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wptr_nxt     = r_wptr;
        w_ram_we       = 1'b0;
        w_commit       = 1'b0;
        w_drop_evt     = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (wr_en && !wr_abort) begin
                    if (!r_full) begin
                        w_ram_we = 1'b1;
                        if (wr_last) begin
                            w_commit = 1'b1;
                        end else begin
                            w_wptr_nxt     = c_WPTR_ONE;
                            w_wr_state_nxt = WR_FILL;
                        end
                    end else begin
                        // No free slot at frame start: the whole frame is lost.
                        w_drop_evt = 1'b1;
                        if (!wr_last) begin
                            w_wr_state_nxt = WR_DROP;
                        end
                    end
                end
            end
            WR_FILL: begin
                if (wr_abort) begin
                    w_drop_evt     = 1'b1;
                    w_wptr_nxt     = '0;
                    w_wr_state_nxt = WR_IDLE;
                end else if (wr_en) begin
                    if (wr_last) begin
                        w_ram_we       = 1'b1;
                        w_commit       = 1'b1;
                        w_wptr_nxt     = '0;
                        w_wr_state_nxt = WR_IDLE;
                    end else if (r_wptr == c_WPTR_MAX) begin
                        // Slot exhausted and frame still going: overflow.
                        w_drop_evt     = 1'b1;
                        w_wptr_nxt     = '0;
                        w_wr_state_nxt = WR_DROP;
                    end else begin
                        w_ram_we   = 1'b1;
                        w_wptr_nxt = r_wptr + c_WPTR_ONE;
                    end
                end
            end
            WR_DROP: begin
                if (wr_abort || (wr_en && wr_last)) begin
                    w_wr_state_nxt = WR_IDLE;
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= WR_IDLE;
            r_wptr     <= '0;
            r_wslot    <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wptr     <= w_wptr_nxt;
            if (w_commit) begin
                r_wslot <= r_wslot + c_SLOT_ONE;
            end
        end
    end

    // Length table is only consulted for committed slots, so no reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_len[r_wslot] <= w_commit_len;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_t             r_rd_state, w_rd_state_nxt;
    logic [NSLOTS_W-1:0]   r_rslot, w_rslot_nxt;
    logic [ADDR_W-1:0]     r_rptr, w_rptr_nxt;
    logic                  w_ram_re;
    logic                  w_rd_done;
    logic                  r_rd_valid, w_rd_valid_nxt;
    logic                  r_rd_last, w_rd_last_nxt;
    logic [ADDR_W:0]       r_rd_len, w_rd_len_nxt;

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rslot_nxt    = r_rslot;
        w_rptr_nxt     = r_rptr;
        w_ram_re       = 1'b0;
        w_rd_done      = 1'b0;
        w_rd_valid_nxt = r_rd_valid;
        w_rd_last_nxt  = r_rd_last;
        w_rd_len_nxt   = r_rd_len;
        case (r_rd_state)
            RD_IDLE: begin
                if (!r_empty) begin
                    w_ram_re       = 1'b1;
                    w_rptr_nxt     = '0;
                    w_rd_state_nxt = RD_FETCH;
                end
            end
            RD_FETCH: begin
                w_rd_valid_nxt = 1'b1;
                w_rd_last_nxt  = (r_len[r_rslot] == c_LEN_ONE);
                w_rd_len_nxt   = r_len[r_rslot];
                w_rd_state_nxt = RD_STREAM;
            end
            RD_STREAM: begin
                // rptr indexes the beat currently presented on rd_data.
                if (rd_ready) begin
                    if (r_rd_last) begin
                        w_rd_done      = 1'b1;
                        w_rslot_nxt    = r_rslot + c_SLOT_ONE;
                        w_rptr_nxt     = '0;
                        w_rd_valid_nxt = 1'b0;
                        w_rd_last_nxt  = 1'b0;
                        // Only frames already counted are fetched here; a frame
                        // committing this very cycle is picked up from IDLE.
                        if (r_frame_cnt > c_CNT_ONE) begin
                            w_ram_re       = 1'b1;
                            w_rd_state_nxt = RD_FETCH;
                        end else begin
                            w_rd_state_nxt = RD_IDLE;
                        end
                    end else begin
                        w_ram_re      = 1'b1;
                        w_rptr_nxt    = r_rptr + c_WPTR_ONE;
                        w_rd_last_nxt = (({1'b0, r_rptr} + c_LEN_TWO) == r_rd_len);
                    end
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
            r_rslot    <= '0;
            r_rptr     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_len   <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rslot    <= w_rslot_nxt;
            r_rptr     <= w_rptr_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_last  <= w_rd_last_nxt;
            r_rd_len   <= w_rd_len_nxt;
        end
    end

    iob_eth_frame_buf_ram #(
        .ADDR_W (c_RAM_ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr ({r_wslot, r_wptr}),
        .i_wdata (wr_data),
        .i_re    (w_ram_re),
        .i_raddr ({w_rslot_nxt, w_rptr_nxt}),
        .o_rdata (rd_data)
    );

    // ------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------
    always_comb begin
        w_frame_cnt_nxt = r_frame_cnt;
        if (w_commit && !w_rd_done) begin
            w_frame_cnt_nxt = r_frame_cnt + c_CNT_ONE;
        end else if (!w_commit && w_rd_done) begin
            w_frame_cnt_nxt = r_frame_cnt - c_CNT_ONE;
        end
    end

    // full/empty are registered from the next count so they always agree
    // with frame_cnt in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
        end else begin
            r_frame_cnt <= w_frame_cnt_nxt;
            r_full      <= (w_frame_cnt_nxt == c_FULL_CNT);
            r_empty     <= (w_frame_cnt_nxt == '0);
        end
    end

`ifdef IOB_ETH_FRAME_BUF_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Counted once on entry to a drop, so each lost frame counts exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop_evt) begin
            r_drop_cnt <= sat_inc16(r_drop_cnt);
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop_evt;
`endif

    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign rd_len    = r_rd_len;
    assign frame_cnt = r_frame_cnt;
    assign full      = r_full;
    assign empty     = r_empty;

endmodule

`default_nettype wire

// File: tb/tb_iob_eth_frame_buf.sv
// ============================================================================
// Module      : tb_iob_eth_frame_buf
// Description : Self-checking bench for iob_eth_frame_buf. A queue-based
//               model of committed frames predicts the read stream and the
//               occupancy outputs; every negedge the DUT is compared against
//               it. Directed scenarios plus a randomized mix.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_eth_frame_buf;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 11;
    localparam int NSLOTS_W = 2;
    localparam int NSLOTS   = 4;
    localparam int MAXLEN   = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_last = 1'b0;
    logic              wr_abort = 1'b0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic [ADDR_W:0]   rd_len;
    logic [NSLOTS_W:0] frame_cnt;
    logic              full;
    logic              empty;
`ifdef IOB_ETH_FRAME_BUF_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    iob_eth_frame_buf #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NSLOTS_W (NSLOTS_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .wr_abort  (wr_abort),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .rd_len    (rd_len),
        .frame_cnt (frame_cnt),
        .full      (full),
        .empty     (empty)
`ifdef IOB_ETH_FRAME_BUF_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] exp_q[$];   // bytes of committed, not yet read frames
    int         len_q[$];   // their lengths
    logic [7:0] cur_q[$];   // frame being received
    int         mode = 0;   // 0 between frames, 1 keeping, 2 discarding
    int         m_cnt = 0;
    int         m_drop = 0;
    int         m_rd_pos = 0;
    int         commit, done;
    logic       p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
    logic [7:0] p_data = '0;
    int         frames_read = 0, beats_read = 0;
    logic [7:0] last_byte = '0;
    int         last_len_obs = 0;

    function automatic int sat16(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("rst_rd_valid", rd_valid, 0);
            check("rst_rd_last", rd_last, 0);
            check("rst_rd_len", rd_len, 0);
            check("rst_frame_cnt", frame_cnt, 0);
            check("rst_full", full, 0);
            check("rst_empty", empty, 1);
            exp_q.delete(); len_q.delete(); cur_q.delete();
            mode = 0; m_cnt = 0; m_drop = 0; m_rd_pos = 0; p_valid = 1'b0;
        end else begin
            check("frame_cnt", frame_cnt, m_cnt);
            check("full", full, (m_cnt == NSLOTS));
            check("empty", empty, (m_cnt == 0));
`ifdef IOB_ETH_FRAME_BUF_DROP_CNT_EN
            check("drop_cnt", drop_cnt, m_drop);
`endif
            if (p_valid && !p_ready) begin
                check("stall_valid", rd_valid, 1);
                check("stall_data", rd_data, p_data);
                check("stall_last", rd_last, p_last);
            end
            if (rd_valid) begin
                if (len_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_valid_no_frame: actual rd_valid 1 required 0 at %0t", $time);
                end else begin
                    check("rd_data", rd_data, exp_q[0]);
                    check("rd_last", rd_last, (m_rd_pos == len_q[0] - 1));
                    check("rd_len", rd_len, len_q[0]);
                end
            end

            commit = 0;
            done   = 0;
            if (rd_valid && rd_ready && len_q.size() > 0) begin
                void'(exp_q.pop_front());
                beats_read++;
                m_rd_pos++;
                if (rd_last) begin
                    last_byte    = rd_data;
                    last_len_obs = int'(rd_len);
                end
                if (m_rd_pos == len_q[0]) begin
                    void'(len_q.pop_front());
                    m_rd_pos = 0;
                    done = 1;
                    frames_read++;
                end
            end

            if (mode == 1) begin
                if (wr_abort) begin
                    cur_q.delete(); mode = 0; m_drop = sat16(m_drop);
                end else if (wr_en) begin
                    if (wr_last) begin
                        cur_q.push_back(wr_data);
                        foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                        len_q.push_back(cur_q.size());
                        cur_q.delete(); commit = 1; mode = 0;
                    end else if (cur_q.size() == MAXLEN - 1) begin
                        cur_q.delete(); mode = 2; m_drop = sat16(m_drop);
                    end else begin
                        cur_q.push_back(wr_data);
                    end
                end
            end else if (mode == 2) begin
                if (wr_abort || (wr_en && wr_last)) mode = 0;
            end else begin
                if (wr_en && !wr_abort) begin
                    if (m_cnt == NSLOTS) begin
                        m_drop = sat16(m_drop);
                        if (!wr_last) mode = 2;
                    end else if (wr_last) begin
                        exp_q.push_back(wr_data); len_q.push_back(1); commit = 1;
                    end else begin
                        cur_q.push_back(wr_data); mode = 1;
                    end
                end
            end
            m_cnt = m_cnt + commit - done;

            p_valid = rd_valid; p_ready = rd_ready; p_data = rd_data; p_last = rd_last;
        end
    end

    // ---------------- stimulus ----------------
    int ready_mode = 1;   // 0 low, 1 high, 2 random

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rd_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wr();
        wr_en = 1'b0; wr_last = 1'b0; wr_abort = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        wr_en = 1'b1; wr_data = d; wr_last = last; wr_abort = 1'b0;
        tick();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((len_q.size() != 0 || rd_valid) && k < budget) begin
            tick();
            k++;
        end
        tick();
        check("drain_pending_frames", len_q.size(), 0);
    endtask

    int mark_f, mark_b, flen, fab, k;

    initial begin
        ready_mode = 1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1) 64-beat counting frame
        mark_f = frames_read; mark_b = beats_read;
        for (int i = 0; i < 64; i++) beat(8'(i), (i == 63));
        idle_wr();
        check("t1_frame_cnt_after_commit", frame_cnt, 1);
        drain(400);
        check("t1_beats", beats_read - mark_b, 64);
        check("t1_frames", frames_read - mark_f, 1);
        check("t1_rd_len", last_len_obs, 64);
        check("t1_last_byte", last_byte, 8'h3F);
        check("t1_frame_cnt_end", frame_cnt, 0);

        // 2) fill all slots, fifth frame dropped
        ready_mode = 0;
        tick();
        mark_f = frames_read;
        for (int i = 0; i < 4; i++) beat(8'hA0 + 8'(i), 1'b1);
        idle_wr();
        tick();
        check("t2_full", full, 1);
        check("t2_frame_cnt", frame_cnt, 4);
        beat(8'hA4, 1'b1);
        idle_wr();
        tick();
        check("t2_frame_cnt_after_drop", frame_cnt, 4);
        ready_mode = 1;
        drain(200);
        check("t2_frames", frames_read - mark_f, 4);
        check("t2_last_byte", last_byte, 8'hA3);
`ifdef IOB_ETH_FRAME_BUF_DROP_CNT_EN
        check("t2_drop_cnt", drop_cnt, 1);
`endif

        // 3) overflow then a maximum-length frame
        mark_f = frames_read;
        for (int i = 0; i < 2049; i++) beat(8'($urandom), 1'b0);
        beat(8'h55, 1'b1);
        idle_wr();
        tick();
        check("t3_frame_cnt_overflow", frame_cnt, 0);
        for (int i = 0; i < MAXLEN; i++) beat(8'($urandom), (i == MAXLEN - 1));
        idle_wr();
        drain(2600);
        check("t3_frames", frames_read - mark_f, 1);
        check("t3_rd_len", last_len_obs, 2048);

        // 4) abort after 10 beats, then A,B,C
        mark_f = frames_read;
        for (int i = 0; i < 10; i++) beat(8'hE0 + 8'(i), 1'b0);
        wr_en = 1'b1; wr_abort = 1'b1; wr_last = 1'b0; wr_data = 8'hEE;
        tick();
        beat(8'h0A, 1'b0); beat(8'h0B, 1'b0); beat(8'h0C, 1'b1);
        idle_wr();
        drain(100);
        check("t4_frames", frames_read - mark_f, 1);
        check("t4_rd_len", last_len_obs, 3);
        check("t4_last_byte", last_byte, 8'h0C);

        // 5) three back-to-back frames with random backpressure
        ready_mode = 2;
        mark_f = frames_read;
        for (int f = 0; f < 3; f++) begin
            flen = $urandom_range(1, 40);
            for (int i = 0; i < flen; i++) beat(8'($urandom), (i == flen - 1));
        end
        idle_wr();
        drain(2000);
        check("t5_frames", frames_read - mark_f, 3);

        // 6) reset during STREAM and during FILL
        ready_mode = 1;
        for (int i = 0; i < 30; i++) beat(8'(i + 100), (i == 29));
        idle_wr();
        k = 0;
        while (!rd_valid && k < 40) begin tick(); k++; end
        check("t6_streaming", rd_valid, 1);
        rst = 1'b1;
        tick();
        check("t6_rst_rd_valid", rd_valid, 0);
        check("t6_rst_empty", empty, 1);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) beat(8'(i), 1'b0);
        idle_wr();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t6_fill_rst_cnt", frame_cnt, 0);
        mark_f = frames_read;
        for (int i = 0; i < 5; i++) beat(8'hC0 + 8'(i), (i == 4));
        idle_wr();
        drain(100);
        check("t6_frames", frames_read - mark_f, 1);
        check("t6_rd_len", last_len_obs, 5);
        check("t6_last_byte", last_byte, 8'hC4);

        // random mix: aborts, gaps, full-time drops, random backpressure
        ready_mode = 2;
        for (int f = 0; f < 30; f++) begin
            flen = $urandom_range(1, 12);
            fab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, flen - 1)) : -1;
            for (int i = 0; i < flen; i++) begin
                if (i == fab) begin
                    wr_en = 1'($urandom_range(0, 1)); wr_abort = 1'b1; wr_last = 1'b0;
                    tick();
                    break;
                end
                beat(8'($urandom), (i == flen - 1));
            end
            idle_wr();
            if ($urandom_range(0, 2) == 0) tick();
        end
        drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        n_bad++;
        $display("FAIL watchdog: actual timeout required completion at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
